// File: rtl/store_align_queue.sv
// store_align_queue: write-side store path. Each accepted store (sb/sh/sw) has
// its data replicated onto the byte lanes and gets a byte-write mask. Legal,
// aligned stores are queued in a small FIFO that drains in order to the dcache.
// Misaligned or illegal ops complete their handshake, are dropped, and raise a
// one-cycle misalign pulse. ld_conflict reports whether any queued store hits
// the same word as the load currently in the MEM stage.
module store_align_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        dc_req_valid,
    input  logic        dc_req_ready,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_wmask,
    output logic        misalign,
    input  logic [31:0] ld_check_addr,
    output logic        ld_conflict,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [29:0]      q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [3:0]       q_mask [DEPTH];
    logic [DEPTH-1:0] q_valid;

    logic [31:0] lane_data;
    logic [3:0]  lane_mask;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;

    // The low two load-address bits play no part in a word-granular compare.
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_check_addr[1:0];

    // No push-through: a full queue refuses even while a pop is in progress.
    assign st_ready     = (count != FULL_CNT);
    assign empty        = (count == '0);
    assign dc_req_valid = !empty;
    assign accept       = st_valid && st_ready;
    assign push         = accept && legal;
    assign pop          = dc_req_valid && dc_req_ready;

    assign dc_addr  = {q_addr[rd_ptr], 2'b00};
    assign dc_wdata = q_data[rd_ptr];
    assign dc_wmask = q_mask[rd_ptr];

    // Lane replication, byte mask and legality of the offered store.
    always_comb begin
        lane_data = st_data;
        lane_mask = 4'b0000;
        legal     = 1'b0;
        case (st_funct3)
            3'd0: begin
                lane_data = {4{st_data[7:0]}};
                lane_mask = 4'b0001 << st_addr[1:0];
                legal     = 1'b1;
            end
            3'd1: begin
                lane_data = {2{st_data[15:0]}};
                lane_mask = st_addr[1] ? 4'b1100 : 4'b0011;
                legal     = !st_addr[0];
            end
            3'd2: begin
                lane_data = st_data;
                lane_mask = 4'b1111;
                legal     = (st_addr[1:0] == 2'b00);
            end
            default: begin
                lane_data = st_data;
                lane_mask = 4'b0000;
                legal     = 1'b0;
            end
        endcase
    end

    // Entry storage: written at the write pointer on every enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
                q_mask[i] <= '0;
            end
        end else if (push) begin
            q_addr[wr_ptr] <= st_addr[31:2];
            q_data[wr_ptr] <= lane_data;
            q_mask[wr_ptr] <= lane_mask;
        end
    end

    // Per-entry occupancy, used by the load conflict compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= '0;
        end else begin
            if (pop)  q_valid[rd_ptr] <= 1'b0;
            if (push) q_valid[wr_ptr] <= 1'b1;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Misalign pulse for a consumed-but-dropped op, one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= accept && !legal;
    end

    // Word-address match against every occupied entry.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_addr[i] == ld_check_addr[31:2])) ld_conflict = 1'b1;
        end
    end

endmodule

// File: tb/tb_store_align_queue.sv
// Bench for store_align_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the store path.
module tb_store_align_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wmask;
    logic        misalign;
    logic [31:0] ld_check_addr;
    logic        ld_conflict;
    logic        empty;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        ok;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } ent_t;

    ent_t q[$];
    logic exp_misalign = 1'b0;

    store_align_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_funct3(st_funct3),
        .st_addr(st_addr), .st_data(st_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
        .misalign(misalign), .ld_check_addr(ld_check_addr),
        .ld_conflict(ld_conflict), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference: a store of sz bytes covers lanes [a%4, a%4+sz); lane i takes
    // byte (i mod sz) of the data; it is legal only if a is a multiple of sz.
    function automatic ent_t make_ent(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        ent_t e;
        int sz;
        int lo;
        sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        lo = int'(a % 4);
        e.ok    = (f3 <= 3'd2) && ((a % sz) == 0);
        e.addr  = a - (a % 4);
        e.wdata = '0;
        e.mask  = '0;
        for (int i = 0; i < 4; i++) begin
            e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
            if (i >= lo && i < lo + sz) e.mask[i] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic model_conflict(logic [31:0] la);
        logic hit;
        hit = 1'b0;
        foreach (q[k]) if ((q[k].addr >> 2) == (la >> 2)) hit = 1'b1;
        return hit;
    endfunction

    task automatic drive(logic v, logic [2:0] f3, logic [31:0] a, logic [31:0] d, logic rdy);
        st_valid     = v;
        st_funct3    = f3;
        st_addr      = a;
        st_data      = d;
        dc_req_ready = rdy;
    endtask

    // Advance one clock and move the model with it; leaves time at the negedge.
    task automatic tick();
        logic acc;
        logic pp;
        ent_t e;
        acc = st_valid && (q.size() < DEPTH);
        pp  = (q.size() > 0) && dc_req_ready;
        e   = make_ent(st_funct3, st_addr, st_data);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc && e.ok) q.push_back(e);
        exp_misalign = acc && !e.ok;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        ld_check_addr = 32'h0;
        repeat (2) @(negedge clk);
        q.delete();
        exp_misalign = 1'b0;
        n_checks++; if ({empty, dc_req_valid, st_ready, misalign} !== 4'b1010)
            $display("FAIL reset_state got %b required 1010", {empty, dc_req_valid, st_ready, misalign});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sb();
        drive(1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        n_checks++; if ({dc_req_valid, dc_addr, dc_wdata, dc_wmask} !== {1'b1, 32'h1000, 32'hABAB_ABAB, 4'b1000})
            $display("FAIL sb_head got v=%b a=%h d=%h m=%b required 1 00001000 abababab 1000",
                     dc_req_valid, dc_addr, dc_wdata, dc_wmask);
        else n_pass++;
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) $display("FAIL sb_drain got empty=%b required 1", empty);
        else n_pass++;
    endtask

    task automatic test_sh();
        drive(1'b1, 3'd1, 32'h2002, 32'h0000_1234, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        #1;
        n_checks++; if ({dc_wdata, dc_wmask} !== {32'h1234_1234, 4'b1100})
            $display("FAIL sh_head got d=%h m=%b required 12341234 1100", dc_wdata, dc_wmask);
        else n_pass++;
        tick();
        drive(1'b1, 3'd1, 32'h2001, 32'h0000_1234, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        n_checks++; if ({misalign, empty, dc_req_valid} !== 3'b110)
            $display("FAIL sh_misalign got m=%b e=%b v=%b required 110", misalign, empty, dc_req_valid);
        else n_pass++;
        tick();
        n_checks++; if ({misalign, empty} !== 2'b01)
            $display("FAIL sh_pulse_end got m=%b e=%b required 01", misalign, empty);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        drive(1'b1, 3'd2, 32'h40, 32'hAAAA_0040, 1'b0);
        tick();
        drive(1'b1, 3'd2, 32'h44, 32'hAAAA_0044, 1'b0);
        tick();
        drive(1'b1, 3'd2, 32'h48, 32'hAAAA_0048, 1'b0);
        #1;
        n_checks++; if (st_ready !== 1'b0) $display("FAIL bp_full got st_ready=%b required 0", st_ready);
        else n_pass++;
        repeat (2) tick();
        n_checks++; if ({st_ready, dc_addr} !== {1'b0, 32'h40})
            $display("FAIL bp_hold got rdy=%b a=%h required 0 00000040", st_ready, dc_addr);
        else n_pass++;
        dc_req_ready = 1'b1;
        tick();
        #1;
        n_checks++; if ({st_ready, dc_addr} !== {1'b1, 32'h44})
            $display("FAIL bp_no_pushthrough got rdy=%b a=%h required 1 00000044", st_ready, dc_addr);
        else n_pass++;
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        #1;
        n_checks++; if ({dc_req_valid, dc_addr, dc_wdata} !== {1'b1, 32'h48, 32'hAAAA_0048})
            $display("FAIL bp_third got v=%b a=%h d=%h required 1 00000048 aaaa0048", dc_req_valid, dc_addr, dc_wdata);
        else n_pass++;
        tick();
        n_checks++; if (empty !== 1'b1) $display("FAIL bp_drain got empty=%b required 1", empty);
        else n_pass++;
    endtask

    task automatic test_conflict();
        drive(1'b1, 3'd2, 32'h100, 32'h5555_5555, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        ld_check_addr = 32'h102;
        #1;
        n_checks++; if (ld_conflict !== 1'b1) $display("FAIL conflict_hit got %b required 1", ld_conflict);
        else n_pass++;
        ld_check_addr = 32'h104;
        #1;
        n_checks++; if (ld_conflict !== 1'b0) $display("FAIL conflict_miss got %b required 0", ld_conflict);
        else n_pass++;
        ld_check_addr = 32'h102;
        dc_req_ready  = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        #1;
        n_checks++; if (ld_conflict !== 1'b0) $display("FAIL conflict_after_pop got %b required 0", ld_conflict);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 3'd2, 32'h200, 32'h1, 1'b0);
        tick();
        drive(1'b1, 3'd2, 32'h204, 32'h2, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_misalign = 1'b0;
        n_checks++; if ({empty, dc_req_valid, st_ready} !== 3'b101)
            $display("FAIL async_reset got e=%b v=%b rdy=%b required 101", empty, dc_req_valid, st_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd3, 32'h300, 32'h3, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        n_checks++; if ({misalign, empty} !== 2'b11)
            $display("FAIL illegal_f3 got m=%b e=%b required 11", misalign, empty);
        else n_pass++;
        tick();
        n_checks++; if (misalign !== 1'b0) $display("FAIL illegal_pulse_end got %b required 0", misalign);
        else n_pass++;
    endtask

    task automatic test_random();
        int max_seen;
        max_seen = 0;
        for (int c = 0; c < 600; c++) begin
            st_valid      = ($urandom_range(0, 9) < 6);
            st_funct3     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            st_addr       = 32'h300 + 32'($urandom_range(0, 15));
            st_data       = $urandom;
            dc_req_ready  = ($urandom_range(0, 1) == 1);
            ld_check_addr = 32'h300 + 32'($urandom_range(0, 19));
            #1;
            n_checks++; if ({st_ready, dc_req_valid, empty} !== {q.size() < DEPTH, q.size() > 0, q.size() == 0})
                $display("FAIL rnd_flags c=%0d got rdy=%b v=%b e=%b for %0d entries", c, st_ready, dc_req_valid, empty, q.size());
            else n_pass++;
            n_checks++; if (misalign !== exp_misalign)
                $display("FAIL rnd_misalign c=%0d got %b required %b", c, misalign, exp_misalign);
            else n_pass++;
            n_checks++; if (ld_conflict !== model_conflict(ld_check_addr))
                $display("FAIL rnd_conflict c=%0d got %b required %b", c, ld_conflict, model_conflict(ld_check_addr));
            else n_pass++;
            if (q.size() > 0) begin
                n_checks++; if ({dc_addr, dc_wdata, dc_wmask} !== {q[0].addr, q[0].wdata, q[0].mask})
                    $display("FAIL rnd_head c=%0d got a=%h d=%h m=%b required a=%h d=%h m=%b",
                             c, dc_addr, dc_wdata, dc_wmask, q[0].addr, q[0].wdata, q[0].mask);
                else n_pass++;
            end
            if (q.size() > max_seen) max_seen = q.size();
            tick();
        end
        n_checks++; if (max_seen != DEPTH) $display("FAIL rnd_fill got max %0d required %0d", max_seen, DEPTH);
        else n_pass++;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        repeat (DEPTH + 1) tick();
        n_checks++; if (empty !== 1'b1) $display("FAIL rnd_drain got empty=%b required 1", empty);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_backpressure();
        test_conflict();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish required finish");
        $fatal(1);
    end

endmodule
